// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl - command controller for the UART system, reference clock domain.
// Parses command frames from the RX synchroniser and drives the register file,
// the ALU and its clock gate, and the TX FIFO write port.
//   Opcodes: 0xAA RF write [addr,data]   0xBB RF read [addr]
//            0xCC ALU [A,B,func]         0xDD ALU [func]   0xEE burst read [addr,count]
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   RX_P_DATA / RX_P_VLD        received byte + one-cycle valid pulse
//   RdData / RdData_Valid       RF read response
//   ALU_OUT / OUT_VALID         ALU result
//   FIFO_FULL                   TX FIFO full
//   ALU_FUNC, ALU_EN, CLK_EN    ALU function (registered), start pulse, clock-gate enable
//   RF_ADDR, WrEn, RdEn, WrData RF access
//   TX_DATA, WR_INC             TX FIFO write
//   clk_div_en                  UART clock-divider enable (constant 1)
//   CMD_ERR                     pulse on unknown opcode or inter-byte timeout
//   BUSY                        high whenever not IDLE
module sys_cmd_ctrl #(
    parameter int FRAME_WIDTH    = 8,
    parameter int ALU_DATA_WIDTH = 16,
    parameter int ALU_FUNC_WIDTH = 4,
    parameter int REG_FILE_DEPTH = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [FRAME_WIDTH-1:0]            RX_P_DATA,
    input  logic                              RX_P_VLD,
    input  logic [FRAME_WIDTH-1:0]            RdData,
    input  logic                              RdData_Valid,
    input  logic [ALU_DATA_WIDTH-1:0]         ALU_OUT,
    input  logic                              OUT_VALID,
    input  logic                              FIFO_FULL,
    output logic [ALU_FUNC_WIDTH-1:0]         ALU_FUNC,
    output logic                              ALU_EN,
    output logic                              CLK_EN,
    output logic [$clog2(REG_FILE_DEPTH)-1:0] RF_ADDR,
    output logic                              WrEn,
    output logic                              RdEn,
    output logic [FRAME_WIDTH-1:0]            WrData,
    output logic [FRAME_WIDTH-1:0]            TX_DATA,
    output logic                              WR_INC,
    output logic                              clk_div_en,
    output logic                              CMD_ERR,
    output logic                              BUSY
);
    localparam int ADDR_W = $clog2(REG_FILE_DEPTH);
    localparam int NB     = (ALU_DATA_WIDTH + FRAME_WIDTH - 1) / FRAME_WIDTH;
    localparam int SW     = NB * FRAME_WIDTH;
    localparam int NLW    = $clog2(NB + 1);
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FRAME_WIDTH-1:0] OP_WR  = FRAME_WIDTH'(8'hAA);
    localparam logic [FRAME_WIDTH-1:0] OP_RD  = FRAME_WIDTH'(8'hBB);
    localparam logic [FRAME_WIDTH-1:0] OP_ALU = FRAME_WIDTH'(8'hCC);
    localparam logic [FRAME_WIDTH-1:0] OP_ALN = FRAME_WIDTH'(8'hDD);
    localparam logic [FRAME_WIDTH-1:0] OP_BR  = FRAME_WIDTH'(8'hEE);

    typedef enum logic [3:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_A, S_GET_B, S_GET_FUNC, S_GET_CNT,
        S_RF_WR, S_RF_RD, S_WAIT_RD, S_ALU_RUN, S_WAIT_ALU, S_SEND
    } state_t;

    state_t                    r_state, w_next;
    logic [FRAME_WIDTH-1:0]    r_op;
    logic [ADDR_W-1:0]         r_addr;
    logic [FRAME_WIDTH-1:0]    r_wdata;
    logic [FRAME_WIDTH-1:0]    r_cnt;
    logic [ALU_FUNC_WIDTH-1:0] r_func;
    logic [SW-1:0]             r_shift;
    logic [NLW-1:0]            r_nleft;
    logic [TW-1:0]             r_tmo;
    logic                      r_err;
    logic                      w_err;
    logic                      w_get;
    logic                      w_tmo_hit;

    assign w_get = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA) || (r_state == S_GET_A) ||
                   (r_state == S_GET_B)    || (r_state == S_GET_FUNC) || (r_state == S_GET_CNT);
    // A byte arriving on the terminal cycle wins over the timeout.
    assign w_tmo_hit = w_get && !RX_P_VLD && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    assign ALU_FUNC   = r_func;
    assign RF_ADDR    = r_addr;
    assign WrData     = r_wdata;
    assign TX_DATA    = r_shift[FRAME_WIDTH-1:0];
    assign CMD_ERR    = r_err;
    assign BUSY       = (r_state != S_IDLE);
    assign clk_div_en = 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        ALU_EN = 1'b0;
        CLK_EN = 1'b0;
        WrEn   = 1'b0;
        RdEn   = 1'b0;
        WR_INC = 1'b0;
        case (r_state)
            S_IDLE: if (RX_P_VLD) begin
                case (RX_P_DATA)
                    OP_WR, OP_RD, OP_BR: w_next = S_GET_ADDR;
                    OP_ALU:              w_next = S_GET_A;
                    OP_ALN:              w_next = S_GET_FUNC;
                    default:             w_err  = 1'b1;
                endcase
            end
            S_GET_ADDR: if (RX_P_VLD)
                w_next = (r_op == OP_WR) ? S_GET_DATA : (r_op == OP_BR) ? S_GET_CNT : S_RF_RD;
            S_GET_DATA, S_GET_A, S_GET_B: if (RX_P_VLD) w_next = S_RF_WR;
            S_GET_FUNC: if (RX_P_VLD) w_next = S_ALU_RUN;
            S_GET_CNT:  if (RX_P_VLD) w_next = (RX_P_DATA == '0) ? S_IDLE : S_RF_RD;
            S_RF_WR: begin
                WrEn = 1'b1;
                // Operand A lands at address 0, B at address 1.
                if (r_op == OP_ALU) w_next = (r_addr == '0) ? S_GET_B : S_GET_FUNC;
                else                w_next = S_IDLE;
            end
            S_RF_RD: begin
                RdEn   = 1'b1;
                w_next = S_WAIT_RD;
            end
            S_WAIT_RD: if (RdData_Valid) w_next = S_SEND;
            S_ALU_RUN: begin
                ALU_EN = 1'b1;
                CLK_EN = 1'b1;
                w_next = S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
                CLK_EN = 1'b1;
                if (OUT_VALID) w_next = S_SEND;
            end
            S_SEND: if (!FIFO_FULL) begin
                WR_INC = 1'b1;
                if (r_nleft == NLW'(1))
                    w_next = (r_op == OP_BR && r_cnt > FRAME_WIDTH'(1)) ? S_RF_RD : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_tmo_hit) begin
            w_next = S_IDLE;
            w_err  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_func  <= '0;
            r_shift <= '0;
            r_nleft <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (RX_P_VLD || !w_get) r_tmo <= '0;
            else                    r_tmo <= r_tmo + 1'b1;
            case (r_state)
                S_IDLE:     if (RX_P_VLD) r_op <= RX_P_DATA;
                S_GET_ADDR: if (RX_P_VLD) r_addr <= RX_P_DATA[ADDR_W-1:0];
                S_GET_DATA: if (RX_P_VLD) r_wdata <= RX_P_DATA;
                S_GET_A: if (RX_P_VLD) begin
                    r_wdata <= RX_P_DATA;
                    r_addr  <= '0;
                end
                S_GET_B: if (RX_P_VLD) begin
                    r_wdata <= RX_P_DATA;
                    r_addr  <= ADDR_W'(1);
                end
                S_GET_FUNC: if (RX_P_VLD) r_func <= RX_P_DATA[ALU_FUNC_WIDTH-1:0];
                S_GET_CNT:  if (RX_P_VLD) r_cnt <= RX_P_DATA;
                S_WAIT_RD: if (RdData_Valid) begin
                    r_shift <= SW'(RdData);
                    r_nleft <= NLW'(1);
                end
                S_WAIT_ALU: if (OUT_VALID) begin
                    r_shift <= SW'(ALU_OUT);   // top byte zero-padded
                    r_nleft <= NLW'(NB);
                end
                S_SEND: if (!FIFO_FULL) begin
                    r_shift <= r_shift >> FRAME_WIDTH;
                    r_nleft <= r_nleft - 1'b1;
                    if (r_nleft == NLW'(1) && r_op == OP_BR && r_cnt > FRAME_WIDTH'(1)) begin
                        r_cnt  <= r_cnt - 1'b1;
                        r_addr <= (r_addr == ADDR_W'(REG_FILE_DEPTH - 1)) ? '0 : r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl: stimulus pushes expected RF writes, RF read
// addresses, TX bytes and error pulses; a monitor pops and compares as they appear.
module tb_sys_cmd_ctrl;
    localparam int TMO = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_P_VLD;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        FIFO_FULL;
    logic [3:0]  ALU_FUNC;
    logic        ALU_EN, CLK_EN, WrEn, RdEn, WR_INC, clk_div_en, CMD_ERR, BUSY;
    logic [3:0]  RF_ADDR;
    logic [7:0]  WrData, TX_DATA;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_tx[$];
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    int exp_err = 0;
    int alu_en_seen = 0;

    always #5 CLK = ~CLK;

    sys_cmd_ctrl #(
        .FRAME_WIDTH(8), .ALU_DATA_WIDTH(16), .ALU_FUNC_WIDTH(4),
        .REG_FILE_DEPTH(16), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_P_VLD(RX_P_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
        .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL), .ALU_FUNC(ALU_FUNC),
        .ALU_EN(ALU_EN), .CLK_EN(CLK_EN), .RF_ADDR(RF_ADDR), .WrEn(WrEn),
        .RdEn(RdEn), .WrData(WrData), .TX_DATA(TX_DATA), .WR_INC(WR_INC),
        .clk_div_en(clk_div_en), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register file + ALU environment: read data one cycle after RdEn,
    // ALU result two cycles after ALU_EN (func 0 = A+B, func 2 = A*B).
    initial begin
        logic [7:0]  rf[16];
        logic        rd_pend;
        logic [3:0]  rd_addr;
        int          alu_cnt;
        logic [15:0] alu_res;
        for (int i = 0; i < 16; i++) rf[i] = 8'h10 + 8'(i);
        rd_pend = 1'b0; rd_addr = '0; alu_cnt = 0; alu_res = '0;
        RdData = '0; RdData_Valid = 1'b0; ALU_OUT = '0; OUT_VALID = 1'b0;
        forever begin
            @(negedge CLK);
            if (WrEn) rf[RF_ADDR] = WrData;
            rd_pend = RdEn;
            rd_addr = RF_ADDR;
            if (ALU_EN) begin
                alu_cnt = 2;
                case (ALU_FUNC)
                    4'd0:    alu_res = {8'h00, rf[0]} + {8'h00, rf[1]};
                    4'd2:    alu_res = {8'h00, rf[0]} * {8'h00, rf[1]};
                    default: alu_res = '0;
                endcase
            end
            @(posedge CLK);
            #1;
            RdData_Valid = rd_pend;
            RdData       = rd_pend ? rf[rd_addr] : 8'h00;
            OUT_VALID    = (alu_cnt == 1);
            ALU_OUT      = (alu_cnt == 1) ? alu_res : 16'h0000;
            if (alu_cnt > 0) alu_cnt--;
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (FIFO_FULL) chk("no_write_when_full", 32'(WR_INC), 32'd0);
                if (WR_INC) begin
                    if (exp_tx.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_unexpected: got %0h expected none", TX_DATA);
                    end else chk("tx_byte", 32'(TX_DATA), 32'(exp_tx.pop_front()));
                end
                if (WrEn) begin
                    if (exp_wr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wr_unexpected: got %0h/%0h expected none", RF_ADDR, WrData);
                    end else chk("rf_write", 32'({RF_ADDR, WrData}), 32'(exp_wr.pop_front()));
                end
                if (RdEn) begin
                    if (exp_rd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd_unexpected: got %0h expected none", RF_ADDR);
                    end else chk("rf_read_addr", 32'(RF_ADDR), 32'(exp_rd.pop_front()));
                end
                if (CMD_ERR) begin
                    chk("cmd_err_expected", 32'(exp_err > 0), 32'd1);
                    if (exp_err > 0) exp_err--;
                end
                if (ALU_EN) alu_en_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b; RX_P_VLD = 1'b1;
        @(posedge CLK); #1;
        RX_P_VLD = 1'b0;
        repeat (2) @(posedge CLK);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge CLK);
        while (BUSY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 32'(BUSY), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_clk_div_en"}, 32'(clk_div_en), 32'd1);
        chk({tag, "_strobes"}, 32'({ALU_EN, CLK_EN, WrEn, RdEn, WR_INC, CMD_ERR}), 32'd0);
        chk({tag, "_buses"}, 32'({ALU_FUNC, RF_ADDR, WrData, TX_DATA}), 32'd0);
    endtask

    initial begin
        RST = 1'b1; RX_P_DATA = '0; RX_P_VLD = 1'b0; FIFO_FULL = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("reset");
        @(posedge CLK); #1;
        RST = 1'b0;

        // RF write
        exp_wr.push_back({4'h5, 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C);
        wait_idle("idle_after_rf_write");

        // ALU with operands, result with non-zero top byte: 0x30*0x20 = 0x0600
        exp_wr.push_back({4'h0, 8'h30}); exp_wr.push_back({4'h1, 8'h20});
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h06);
        send(8'hCC); send(8'h30); send(8'h20); send(8'h02);
        wait_idle("idle_after_alu_mul");

        // ALU ADD 7+3 = 0x000A
        exp_wr.push_back({4'h0, 8'h07}); exp_wr.push_back({4'h1, 8'h03});
        exp_tx.push_back(8'h0A); exp_tx.push_back(8'h00);
        send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
        wait_idle("idle_after_alu_add");

        // ALU without operands: 7*3 = 0x0015
        exp_tx.push_back(8'h15); exp_tx.push_back(8'h00);
        send(8'hDD); send(8'h02);
        wait_idle("idle_after_alu_noop");

        // Burst read wrapping 14,15,0,1
        exp_rd.push_back(4'd14); exp_rd.push_back(4'd15);
        exp_rd.push_back(4'd0);  exp_rd.push_back(4'd1);
        exp_tx.push_back(8'h1E); exp_tx.push_back(8'h1F);
        exp_tx.push_back(8'h07); exp_tx.push_back(8'h03);
        send(8'hEE); send(8'h0E); send(8'h04);
        wait_idle("idle_after_burst");

        // Single read held by a full FIFO
        FIFO_FULL = 1'b1;
        exp_rd.push_back(4'd2); exp_tx.push_back(8'h12);
        send(8'hBB); send(8'h02);
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        chk("tx_held_while_full", 32'(exp_tx.size()), 32'd1);
        chk("busy_while_full", 32'(BUSY), 32'd1);
        @(posedge CLK); #1;
        FIFO_FULL = 1'b0;
        wait_idle("idle_after_full_release");

        // Burst with count 0 does nothing
        send(8'hEE); send(8'h03); send(8'h00);
        wait_idle("idle_after_burst_zero");

        // Inter-byte timeout
        exp_err++;
        send(8'hAA); send(8'h05);
        repeat (TMO - 8) @(posedge CLK);
        @(negedge CLK);
        chk("busy_before_timeout", 32'(BUSY), 32'd1);
        chk("no_err_before_timeout", 32'(exp_err), 32'd1);
        wait_idle("idle_after_timeout");
        repeat (2) @(negedge CLK);
        chk("timeout_err_seen", 32'(exp_err), 32'd0);

        // Normal read after timeout
        exp_rd.push_back(4'd5); exp_tx.push_back(8'h3C);
        send(8'hBB); send(8'h05);
        wait_idle("idle_after_read");

        // Unknown opcode
        exp_err++;
        send(8'h55);
        repeat (2) @(negedge CLK);
        chk("bad_opcode_err_seen", 32'(exp_err), 32'd0);
        chk("bad_opcode_idle", 32'(BUSY), 32'd0);

        // Reset mid burst (stalled in SEND by a full FIFO)
        FIFO_FULL = 1'b1;
        exp_rd.push_back(4'd0);
        send(8'hEE); send(8'h00); send(8'h08);
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk("busy_mid_burst", 32'(BUSY), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("mid_reset");
        @(posedge CLK); #1;
        RST = 1'b0; FIFO_FULL = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        chk("idle_after_mid_reset", 32'(BUSY), 32'd0);

        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        chk("alu_en_pulses", 32'(alu_en_seen), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
